// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - state encoding and address-field width helpers shared by the icache files
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    COMMIT = 2'd2
  } state_e;

  function automatic int offset_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int line_words, input int num_lines);
    return 32 - 2 - $clog2(line_words) - $clog2(num_lines);
  endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// rtl/icache_refill_fsm.sv - refill sequencer: state, word counter, line latch and memory handshake
module icache_refill_fsm
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [29-offset_w(LINE_WORDS):0] i_pc_line,
  input  logic                         i_miss,
  input  logic                         i_mem_ack,
  output logic                         o_mem_req,
  output logic [31:0]                  o_mem_addr,
  output logic                         o_idle,
  output logic                         o_data_we,
  output logic                         o_valid_clr,
  output logic                         o_commit,
  output logic [offset_w(LINE_WORDS)-1:0]  o_count,
  output logic [29-offset_w(LINE_WORDS):0] o_line
);

  localparam int OB = offset_w(LINE_WORDS);
  localparam int LB = 30 - OB;

  state_e          r_state;
  logic [OB-1:0]   r_count;
  logic [LB-1:0]   r_line;
  logic            r_mem_req;
  logic [31:0]     r_mem_addr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_line     <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_miss) begin
            r_line     <= i_pc_line;
            r_mem_addr <= {i_pc_line, {(OB + 2){1'b0}}};
            r_mem_req  <= 1'b1;
            r_count    <= '0;
            r_state    <= REFILL;
          end
        end
        REFILL: begin
          if (r_mem_req && i_mem_ack) begin
            r_count <= r_count + 1'b1;
            // LINE_WORDS is a power of two, so the last word is an all-ones counter
            if (&r_count) begin
              r_mem_req <= 1'b0;
              r_state   <= COMMIT;
            end else begin
              r_mem_addr <= r_mem_addr + 32'd4;
            end
          end
        end
        COMMIT: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_mem_req   = r_mem_req;
  assign o_mem_addr  = r_mem_addr;
  assign o_idle      = (r_state == IDLE);
  assign o_data_we   = (r_state == REFILL) && r_mem_req && i_mem_ack;
  assign o_valid_clr = (r_state == IDLE) && i_miss;
  assign o_commit    = (r_state == COMMIT);
  assign o_count     = r_count;
  assign o_line      = r_line;

endmodule

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped instruction cache; optional hit/miss counters via ICACHE_STATS_EN
module icache
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        hit,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int OB = offset_w(LINE_WORDS);
  localparam int IB = index_w(NUM_LINES);
  localparam int TB = tag_w(LINE_WORDS, NUM_LINES);
  localparam int LB = 30 - OB;

  logic [31:0]    r_data [NUM_LINES][LINE_WORDS];
  logic [TB-1:0]  r_tag  [NUM_LINES];
  logic [NUM_LINES-1:0] r_valid;

  logic [OB-1:0]  w_off;
  logic [IB-1:0]  w_idx;
  logic [TB-1:0]  w_tag;
  logic [LB-1:0]  w_line;
  logic [IB-1:0]  w_line_idx;
  logic [TB-1:0]  w_line_tag;
  logic [OB-1:0]  w_count;
  logic           w_miss;
  logic           w_idle;
  logic           w_data_we;
  logic           w_valid_clr;
  logic           w_commit;
  logic           w_unused_pc_lsb;

  assign w_off      = pc[OB+1:2];
  assign w_idx      = pc[OB+IB+1:OB+2];
  assign w_tag      = pc[31:OB+IB+2];
  assign w_line_idx = w_line[IB-1:0];
  assign w_line_tag = w_line[LB-1:IB];
  assign w_unused_pc_lsb = &{1'b0, pc[1:0]};

  assign w_miss      = !(r_valid[w_idx] && (r_tag[w_idx] == w_tag));
  assign hit         = w_idle && !w_miss;
  assign instruction = r_data[w_idx][w_off];

  icache_refill_fsm #(
    .LINE_WORDS (LINE_WORDS)
  ) u_refill_fsm (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_pc_line   (pc[31:OB+2]),
    .i_miss      (w_miss),
    .i_mem_ack   (mem_ack),
    .o_mem_req   (mem_req),
    .o_mem_addr  (mem_addr),
    .o_idle      (w_idle),
    .o_data_we   (w_data_we),
    .o_valid_clr (w_valid_clr),
    .o_commit    (w_commit),
    .o_count     (w_count),
    .o_line      (w_line)
  );

  // Data and tags carry no reset; the valid bits alone gate every lookup.
  always_ff @(posedge clk) begin
    if (w_data_we) r_data[w_line_idx][w_count] <= mem_rdata;
    if (w_commit)  r_tag[w_line_idx] <= w_line_tag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else begin
      if (w_valid_clr) r_valid[w_idx]      <= 1'b0;
      if (w_commit)    r_valid[w_line_idx] <= 1'b1;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (hit)         r_hit_count  <= r_hit_count + 32'd1;
      if (w_valid_clr) r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - randomized self-checking bench for icache against a line-residency model
module tb_icache;

  localparam int LW = 4;
  localparam int NL = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = 32'h0000_0040;
  logic [31:0] instruction;
  logic        hit;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache #(.LINE_WORDS(LW), .NUM_LINES(NL)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .instruction (instruction),
    .hit         (hit),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count   (hit_count),
    .miss_count  (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Memory responder: rdata equals the requested address, ack after a chosen wait.
  int          min_delay = 0;
  int          max_delay = 0;
  bit          noise_en = 1'b0;
  bit          pending = 1'b0;
  int          waited = 0;
  int          cur_delay = 0;
  int          wait_sum = 0;
  int          stable_viol = 0;
  logic [31:0] held_addr = 32'h0;
  logic [31:0] acked_q[$];

  always @(negedge clk) begin
    if (mem_req === 1'b1) begin
      if (!pending) begin
        pending = 1'b1;
        held_addr = mem_addr;
        waited = 0;
        cur_delay = int'($urandom_range(max_delay, min_delay));
      end else if (mem_addr !== held_addr) begin
        stable_viol++;
      end
      if (waited >= cur_delay) begin
        mem_ack = 1'b1;
        mem_rdata = mem_addr;
        acked_q.push_back(mem_addr);
        wait_sum += cur_delay;
        pending = 1'b0;
      end else begin
        mem_ack = 1'b0;
        mem_rdata = $urandom;
        waited++;
      end
    end else begin
      pending = 1'b0;
      mem_ack = noise_en && ($urandom_range(1, 0) == 1);
      mem_rdata = $urandom;
    end
  end

  // Reference model: which memory line each cache slot currently holds.
  bit          m_valid [NL];
  logic [31:0] m_tag   [NL];

  function automatic int m_idx(input logic [31:0] a);
    logic [31:0] ln;
    ln = a / (LW * 4);
    return int'(ln % NL);
  endfunction

  function automatic logic [31:0] m_tagof(input logic [31:0] a);
    return (a / (LW * 4)) / NL;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[m_idx(a)] && (m_tag[m_idx(a)] == m_tagof(a));
  endfunction

  function automatic void model_fill(input logic [31:0] a);
    m_valid[m_idx(a)] = 1'b1;
    m_tag[m_idx(a)] = m_tagof(a);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
  endfunction

  task automatic fetch(input logic [31:0] a, input string name);
    bit          exp_hit;
    int          cyc;
    bit          seq_ok;
    logic [31:0] base;
    exp_hit = model_hit(a);
    base = a & ~32'(LW * 4 - 1);
    wait_sum = 0;
    acked_q.delete();
    @(negedge clk);
    pc = a;
    rst = 1'b0;
    #1;
    n_checks++;
    if (hit !== exp_hit) begin
      n_errors++;
      $display("FAIL %s hit_now pc=%h: got %b expected %b", name, a, hit, exp_hit);
    end
    if (exp_hit) begin
      n_checks++;
      if (instruction !== (a & ~32'd3) || mem_req !== 1'b0) begin
        n_errors++;
        $display("FAIL %s hit_data pc=%h: got instr=%h req=%b expected instr=%h req=0",
                 name, a, instruction, mem_req, a & ~32'd3);
      end
    end else begin
      cyc = 0;
      while (hit !== 1'b1 && cyc < 300) begin
        @(negedge clk);
        #1;
        cyc++;
      end
      n_checks++;
      if (cyc != 2 + LW + wait_sum) begin
        n_errors++;
        $display("FAIL %s miss_latency pc=%h: got %0d cycles expected %0d", name, a, cyc, 2 + LW + wait_sum);
      end
      n_checks++;
      if (instruction !== (a & ~32'd3)) begin
        n_errors++;
        $display("FAIL %s refill_data pc=%h: got %h expected %h", name, a, instruction, a & ~32'd3);
      end
      seq_ok = (acked_q.size() == LW);
      for (int i = 0; i < acked_q.size() && i < LW; i++)
        if (acked_q[i] !== base + 32'(4 * i)) seq_ok = 1'b0;
      n_checks++;
      if (!seq_ok) begin
        n_errors++;
        $display("FAIL %s refill_addrs pc=%h: got %0d reads first=%h expected %0d reads from %h",
                 name, a, acked_q.size(), (acked_q.size() > 0) ? acked_q[0] : 32'hx, LW, base);
      end
      model_fill(a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (hit !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_state: got hit=%b req=%b addr=%h expected 0 0 0", hit, mem_req, mem_addr);
    end
`ifdef ICACHE_STATS_EN
    n_checks++;
    if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_stats: got hits=%0d misses=%0d expected 0 0", hit_count, miss_count);
    end
`endif
    model_clear();
  endtask

  task automatic test_cold_miss();
    min_delay = 0; max_delay = 0; noise_en = 1'b0;
    fetch(32'h0000_0040, "cold_miss");
  endtask

`ifdef ICACHE_STATS_EN
  task automatic test_stats();
    n_checks++;
    if (miss_count !== 32'd1 || hit_count !== 32'd0) begin
      n_errors++;
      $display("FAIL stats_after_miss: got hits=%0d misses=%0d expected 0 1", hit_count, miss_count);
    end
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (miss_count !== 32'd1 || hit_count !== 32'd3) begin
      n_errors++;
      $display("FAIL stats_after_hits: got hits=%0d misses=%0d expected 3 1", hit_count, miss_count);
    end
  endtask
`endif

  task automatic test_hit_same_line();
    fetch(32'h0000_0044, "hit_44");
    fetch(32'h0000_004F, "hit_4c_lsb");
    @(negedge clk);
    #1;
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_errors++;
      $display("FAIL hit_no_request: got mem_req=%b expected 0", mem_req);
    end
  endtask

  task automatic test_conflict();
    fetch(32'h0000_0440, "conflict_440");
    fetch(32'h0000_0040, "conflict_back_40");
  endtask

  task automatic test_delayed_ack();
    min_delay = 3; max_delay = 3; stable_viol = 0;
    fetch(32'h0000_00C0, "delayed_c0");
    n_checks++;
    if (stable_viol != 0) begin
      n_errors++;
      $display("FAIL delayed_addr_stable: got %0d changes expected 0", stable_viol);
    end
  endtask

  task automatic test_branch_mid_refill();
    int cyc;
    bit seq_ok;
    stable_viol = 0;
    acked_q.delete();
    @(negedge clk);
    pc = 32'h0000_0080;
    repeat (6) @(negedge clk);
    pc = 32'h0000_0100;
    cyc = 0;
    while (acked_q.size() < LW && cyc < 200) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    seq_ok = (acked_q.size() == LW);
    for (int i = 0; i < acked_q.size() && i < LW; i++)
      if (acked_q[i] !== 32'h80 + 32'(4 * i)) seq_ok = 1'b0;
    n_checks++;
    if (!seq_ok || stable_viol != 0) begin
      n_errors++;
      $display("FAIL branch_refill_addrs: got %0d reads, %0d addr changes expected 4 reads from 00000080, 0 changes",
               acked_q.size(), stable_viol);
    end
    model_fill(32'h0000_0080);
    cyc = 0;
    while (hit !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    n_checks++;
    if (hit !== 1'b1 || instruction !== 32'h0000_0100) begin
      n_errors++;
      $display("FAIL branch_resume: got hit=%b instr=%h expected 1 00000100", hit, instruction);
    end
    model_fill(32'h0000_0100);
    fetch(32'h0000_0080, "branch_line_kept");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] lines [4];
    lines[0] = 32'h40; lines[1] = 32'h80; lines[2] = 32'hC0; lines[3] = 32'h100;
    for (int i = 0; i < 12; i++) begin
      a = lines[$urandom_range(3, 0)] + 32'($urandom_range(LW - 1, 0) * 4);
      @(negedge clk);
      pc = a;
      #1;
      n_checks++;
      if (hit !== model_hit(a) || (model_hit(a) && instruction !== a) || mem_req !== 1'b0) begin
        n_errors++;
        $display("FAIL back_to_back pc=%h: got hit=%b instr=%h req=%b expected hit=%b instr=%h req=0",
                 a, hit, instruction, mem_req, model_hit(a), a);
      end
    end
  endtask

  task automatic test_reset_mid_refill();
    int cyc;
    min_delay = 0; max_delay = 0;
    acked_q.delete();
    @(negedge clk);
    pc = 32'h0000_0200;
    cyc = 0;
    while (acked_q.size() < 1 && cyc < 50) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0204) begin
      n_errors++;
      $display("FAIL reset_mid_second_word: got req=%b addr=%h expected 1 00000204", mem_req, mem_addr);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || hit !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_async: got req=%b hit=%b expected 0 0", mem_req, hit);
    end
    model_clear();
    @(negedge clk);
    fetch(32'h0000_0040, "after_reset_40");
  endtask

  task automatic test_random();
    logic [31:0] a;
    min_delay = 0; max_delay = 2; noise_en = 1'b1; stable_viol = 0;
    for (int i = 0; i < 40; i++) begin
      a = (32'($urandom_range(47, 0)) << 4) | (32'($urandom_range(3, 0)) << 2) | 32'($urandom_range(3, 0));
      if ($urandom_range(3, 0) == 0) a = a | 32'hFFFF_0000;
      fetch(a, "random");
    end
    n_checks++;
    if (stable_viol != 0) begin
      n_errors++;
      $display("FAIL random_addr_stable: got %0d changes expected 0", stable_viol);
    end
    noise_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
`ifdef ICACHE_STATS_EN
    test_stats();
`endif
    test_hit_same_line();
    test_conflict();
    test_delayed_ack();
    test_branch_mid_refill();
    test_back_to_back();
    test_reset_mid_refill();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
